// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: three-state fetch FSM (StIdle/StReq/StHold) with a
// one-entry skid buffer that absorbs a word acked while decode is stalled.
// Define IF_DELAY_SLOT_EN to keep the word acked in a redirect cycle as the
// branch delay slot. Without it, that word is dropped.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] id_in_d,
  output logic [31:0] id_pc,
  output logic        id_valid
);

  typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  // The buffer is full exactly when the FSM sits in StHold.
  logic [31:0] buf_data_q, buf_data_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] id_in_d_q, id_in_d_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic        id_valid_q, id_valid_d;

  logic [31:0] pc_inc;
  logic [31:0] redirect_tgt;
  logic        unused_redirect_lsb;

  // Word-aligned target; the low bits of redirect_pc are ignored.
  assign redirect_tgt        = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];
  // Natural 32-bit wrap gives the modulo-2^32 increment.
  assign pc_inc              = pc_q + 32'd4;

  // Fetch-side outputs depend on state only.
  always_comb begin
    imem_req  = (state_q == StReq);
    imem_addr = {pc_q[31:2], 2'b00};
    id_in_d   = id_in_d_q;
    id_pc     = id_pc_q;
    id_valid  = id_valid_q;
  end

  // Next-state logic: redirect beats ack and stall; ID outputs hold by default.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_data_d = buf_data_q;
    buf_pc_d   = buf_pc_q;
    id_in_d_d  = id_in_d_q;
    id_pc_d    = id_pc_q;
    id_valid_d = id_valid_q;

    unique case (state_q)
      StIdle: begin
        state_d = StReq;
      end

      StReq: begin
        if (redirect_valid) begin
          pc_d       = redirect_tgt;
          buf_data_d = '0;
          buf_pc_d   = '0;
          state_d    = StReq;
`ifdef IF_DELAY_SLOT_EN
          if (imem_ack && !stall) begin
            id_in_d_d  = imem_rdata;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
          end else if (imem_ack) begin
            // Delay slot parks in the buffer; redirect target is already in pc.
            buf_data_d = imem_rdata;
            buf_pc_d   = pc_q;
            state_d    = StHold;
          end else if (!stall) begin
            id_valid_d = 1'b0;
          end
`else
          id_valid_d = 1'b0;
`endif
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (!stall) begin
            id_in_d_d  = imem_rdata;
            id_pc_d    = pc_q;
            id_valid_d = 1'b1;
          end else begin
            buf_data_d = imem_rdata;
            buf_pc_d   = pc_q;
            state_d    = StHold;
          end
        end else if (!stall) begin
          id_valid_d = 1'b0;
        end
      end

      StHold: begin
        if (redirect_valid) begin
          pc_d       = redirect_tgt;
          buf_data_d = '0;
          buf_pc_d   = '0;
          id_valid_d = 1'b0;
          state_d    = StReq;
        end else if (!stall) begin
          id_in_d_d  = buf_data_q;
          id_pc_d    = buf_pc_q;
          id_valid_d = 1'b1;
          state_d    = StReq;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      buf_data_q <= '0;
      buf_pc_q   <= '0;
      id_in_d_q  <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      buf_data_q <= buf_data_d;
      buf_pc_q   <= buf_pc_d;
      id_in_d_q  <= id_in_d_d;
      id_pc_q    <= id_pc_d;
      id_valid_q <= id_valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: expected ID words are queued when an ack
// is driven and popped when decode should see them. A second instance with
// RESET_PC = 32'hFFFF_FFFC covers PC wraparound.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ack;
  logic        stall;
  logic        rv;
  logic [31:0] rpc;
  logic [31:0] rdata;

  logic        imem_req, w_imem_req;
  logic [31:0] imem_addr, w_imem_addr;
  logic [31:0] id_in_d, w_id_in_d;
  logic [31:0] id_pc, w_id_pc;
  logic        id_valid, w_id_valid;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (ack),
    .imem_rdata     (rdata),
    .stall          (stall),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .id_in_d        (id_in_d),
    .id_pc          (id_pc),
    .id_valid       (id_valid)
  );

  if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (w_imem_req),
    .imem_addr      (w_imem_addr),
    .imem_ack       (ack),
    .imem_rdata     (rdata),
    .stall          (stall),
    .redirect_valid (rv),
    .redirect_pc    (rpc),
    .id_in_d        (w_id_in_d),
    .id_pc          (w_id_pc),
    .id_valid       (w_id_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pop_id(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected a queued word", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
      chk({tag, "_ins"}, id_in_d, e.ins);
      chk({tag, "_pc"}, id_pc, e.pc);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic a, input logic s, input logic r,
                      input logic [31:0] rp, input logic [31:0] rd);
    ack   = a;
    stall = s;
    rv    = r;
    rpc   = rp;
    rdata = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    rst = 1'b1; ack = 1'b0; stall = 1'b0; rv = 1'b0; rpc = '0; rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("rst_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_ins", id_in_d, 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_3000);
    chk("wrap_rst_addr", w_imem_addr, 32'hFFFF_FFFC);

    // First request lands in the second cycle after reset falls
    rst = 1'b0;
    chk("idle_req", {31'd0, imem_req}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0000_3000);

    // Continuous ack, no stall
    for (int i = 0; i < 3; i++) begin
      a = 32'h0000_3000 + 32'(4 * i);
      chk("seq_addr", imem_addr, a);
      sb.push_back('{ins: mem_word(a), pc: a});
      step(1'b1, 1'b0, 1'b0, 32'd0, mem_word(a));
      pop_id("seq");
      if (i == 0) begin
        chk("wrap_addr", w_imem_addr, 32'h0000_0000);
        chk("wrap_id_pc", w_id_pc, 32'hFFFF_FFFC);
      end
    end
    chk("seq_next_addr", imem_addr, 32'h0000_300C);

    // Reset overrides redirect/stall/ack
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b1, 32'h0000_1234, 32'h1111_1111);
    chk("rst2_valid", {31'd0, id_valid}, 32'd0);
    chk("rst2_addr", imem_addr, 32'h0000_3000);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Stall with a word acked at 0x3004
    sb.push_back('{ins: mem_word(32'h3000), pc: 32'h3000});
    step(1'b1, 1'b0, 1'b0, 32'd0, mem_word(32'h3000));
    pop_id("pre_stall");
    sb.push_back('{ins: 32'h2108_0001, pc: 32'h3004});
    step(1'b1, 1'b1, 1'b0, 32'd0, 32'h2108_0001);
    for (int i = 0; i < 3; i++) begin
      chk("hold_req", {31'd0, imem_req}, 32'd0);
      chk("hold_id_pc", id_pc, 32'h3000);
      chk("hold_id_ins", id_in_d, mem_word(32'h3000));
      chk("hold_valid", {31'd0, id_valid}, 32'd1);
      if (i < 2) step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    end
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    pop_id("release");
    chk("release_req", {31'd0, imem_req}, 32'd1);
    chk("release_addr", imem_addr, 32'h3008);

    // No ack: stall holds, no stall inserts a bubble
    sb.push_back('{ins: mem_word(32'h3008), pc: 32'h3008});
    step(1'b1, 1'b0, 1'b0, 32'd0, mem_word(32'h3008));
    pop_id("ack3008");
    step(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    chk("noack_stall_valid", {31'd0, id_valid}, 32'd1);
    chk("noack_stall_pc", id_pc, 32'h3008);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("bubble_valid", {31'd0, id_valid}, 32'd0);
    chk("bubble_addr", imem_addr, 32'h300C);

    // Redirect in the same cycle as an ack
`ifdef IF_DELAY_SLOT_EN
    sb.push_back('{ins: mem_word(32'h300C), pc: 32'h300C});
    step(1'b1, 1'b0, 1'b1, 32'h0000_3043, mem_word(32'h300C));
    pop_id("delay_slot");
`else
    step(1'b1, 1'b0, 1'b1, 32'h0000_3043, mem_word(32'h300C));
    chk("redir_valid", {31'd0, id_valid}, 32'd0);
`endif
    chk("redir_addr", imem_addr, 32'h3040);

    sb.push_back('{ins: mem_word(32'h3040), pc: 32'h3040});
    step(1'b1, 1'b0, 1'b0, 32'd0, mem_word(32'h3040));
    pop_id("ack3040");

    // Redirect with stall and ack
    step(1'b1, 1'b1, 1'b1, 32'h0000_5001, mem_word(32'h3044));
`ifdef IF_DELAY_SLOT_EN
    chk("redir_stall_req", {31'd0, imem_req}, 32'd0);
    sb.push_back('{ins: mem_word(32'h3044), pc: 32'h3044});
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    pop_id("delay_slot_hold");
`else
    chk("redir_stall_valid", {31'd0, id_valid}, 32'd0);
    chk("redir_stall_req", {31'd0, imem_req}, 32'd1);
`endif
    chk("redir_stall_addr", imem_addr, 32'h5000);

    // Reset during HOLD discards the buffered word
    step(1'b1, 1'b1, 1'b0, 32'd0, mem_word(32'h5000));
    chk("hold2_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    step(1'b1, 1'b0, 1'b1, 32'h0000_7000, 32'h2222_2222);
    chk("rst_hold_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_hold_req", {31'd0, imem_req}, 32'd0);
    chk("rst_hold_ins", id_in_d, 32'd0);
    chk("rst_hold_addr", imem_addr, 32'h3000);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rst_hold_req2", {31'd0, imem_req}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("rst_hold_no_word", {31'd0, id_valid}, 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
